alu_multibyte_seq: RTL and testbench

Multi-byte operation sequencer sitting directly upstream of the 8-bit ALU, with the ALU's results fed back into it. It accepts one NBYTES-wide operation and drives the ALU one byte per cycle, least-significant byte first. It chains the carry between bytes and assembles the wide result, carry and zero flags. This gives the datapath 16/32-bit add/subtract/logic without widening the ALU.

---
 rtl/alu_multibyte_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq
//   Sequences one NBYTES-wide operation through an external 8-bit ALU, one
//   byte per cycle, least-significant byte first. The carry is chained between
//   bytes, and the wide result, carry and zero flags are assembled here.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 request, sampled only while idle
//   op_code[2:0]          operation select (0..7)
//   opa, opb [W-1:0]      operands, latched with start
//   cin                   carry-in for byte 0, latched with start
//   alu_oper[79:0]        ASCII op name to the ALU (right-justified, zero-padded)
//   alu_a, alu_b [7:0]    current operand bytes (0 outside RUN)
//   alu_c_in              current carry-in to the ALU (0 outside RUN)
//   alu_sum[7:0]          ALU result byte (combinational return path)
//   alu_c_out             ALU carry out
//   busy                  high whenever not idle
//   done                  one-cycle completion pulse
//   result[W-1:0]         assembled result, held until the next accepted start
//   cout, zero            final carry, result-is-zero
module alu_multibyte_seq #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op_code,
    input  logic [W-1:0]  opa,
    input  logic [W-1:0]  opb,
    input  logic          cin,
    output logic [79:0]   alu_oper,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_c_in,
    input  logic [7:0]    alu_sum,
    input  logic          alu_c_out,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          cout,
    output logic          zero
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [79:0] OPER_RESET = "and";

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [2:0]    op_q, op_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic [79:0]   oper_q, oper_d;

    function automatic logic [79:0] op_name(input logic [2:0] op);
        logic [79:0] s;
        case (op)
            3'd0:    s = "and";
            3'd1:    s = "subtract";
            3'd2:    s = "subtract_a";
            3'd3:    s = "or_ab";
            3'd4:    s = "and_ab";
            3'd5:    s = "not_ab";
            3'd6:    s = "exor";
            default: s = "exnor";
        endcase
        return s;
    endfunction

    // Ops 0..2 are arithmetic and use the carry chain; the rest are bitwise.
    function automatic logic is_arith(input logic [2:0] op);
        return (op <= 3'd2);
    endfunction

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        // alu_oper is loaded on accept so byte 0 already sees the new op.
        oper_d   = oper_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    opa_d    = opa;
                    opb_d    = opb;
                    op_d     = op_code;
                    cin_d    = cin;
                    oper_d   = op_name(op_code);
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[8*i +: 8] = alu_sum;
                    end
                end
                carry_d = alu_c_out;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = is_arith(op_q) ? alu_c_out : 1'b0;
                    // Includes the byte captured on this same edge.
                    zero_d  = (result_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            oper_q   <= OPER_RESET;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            oper_q   <= oper_d;
        end
    end

    // ALU drive: byte select and carry chain
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_c_in = 1'b0;
        if (state_q == S_RUN) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (idx_q == IW'(i)) begin
                    alu_a = opa_q[8*i +: 8];
                    alu_b = opb_q[8*i +: 8];
                end
            end
            if (is_arith(op_q)) begin
                if (idx_q == '0) begin
                    alu_c_in = cin_q;
                end else if (op_q == 3'd2) begin
                    // The ALU inverts c_in for subtract_a, so pre-invert here.
                    alu_c_in = ~carry_q;
                end else begin
                    alu_c_in = carry_q;
                end
            end
        end
    end

    assign alu_oper = oper_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
module tb_alu_multibyte_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    op_code;
    logic [W-1:0]  opa, opb;
    logic          cin;
    logic [79:0]   alu_oper;
    logic [7:0]    alu_a, alu_b;
    logic          alu_c_in;
    logic [7:0]    alu_sum;
    logic          alu_c_out;
    logic          busy, done;
    logic [W-1:0]  result;
    logic          cout, zero;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];

    alu_multibyte_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_code   (op_code),
        .opa       (opa),
        .opb       (opb),
        .cin       (cin),
        .alu_oper  (alu_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c_in  (alu_c_in),
        .alu_sum   (alu_sum),
        .alu_c_out (alu_c_out),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Op names as the ALU understands them
    function automatic logic [79:0] name_of(input logic [2:0] op);
        logic [79:0] s;
        case (op)
            3'd0:    s = "and";
            3'd1:    s = "subtract";
            3'd2:    s = "subtract_a";
            3'd3:    s = "or_ab";
            3'd4:    s = "and_ab";
            3'd5:    s = "not_ab";
            3'd6:    s = "exor";
            default: s = "exnor";
        endcase
        return s;
    endfunction

    // Bench 8-bit ALU; carry out on bitwise ops is deliberately junk (parity)
    logic [7:0] na, lg;
    logic [8:0] t9;
    always_comb begin
        na = ~alu_a;
        lg = '0;
        t9 = '0;
        if (alu_oper == name_of(3'd0))
            t9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
        else if (alu_oper == name_of(3'd1))
            t9 = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'b0, alu_c_in};
        else if (alu_oper == name_of(3'd2))
            t9 = {1'b0, alu_b} + {1'b0, na} + {8'b0, ~alu_c_in};
        else begin
            if (alu_oper == name_of(3'd3))      lg = alu_a | alu_b;
            else if (alu_oper == name_of(3'd4)) lg = alu_a & alu_b;
            else if (alu_oper == name_of(3'd5)) lg = ~(alu_a & alu_b);
            else if (alu_oper == name_of(3'd6)) lg = alu_a ^ alu_b;
            else                                lg = ~(alu_a ^ alu_b);
            t9 = {^lg, lg};
        end
        alu_sum   = t9[7:0];
        alu_c_out = t9[8];
    end

    // Wide reference model
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        exp_t e;
        case (op)
            3'd0: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            3'd1: s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c};
            3'd2: s = {1'b0, b} + {1'b0, ~a} + {{W{1'b0}}, ~c};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a & b};
            3'd5: s = {1'b0, ~(a & b)};
            3'd6: s = {1'b0, a ^ b};
            default: s = {1'b0, ~(a ^ b)};
        endcase
        e.res = s[W-1:0];
        e.c   = s[W];
        e.z   = (s[W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard whenever done is presented
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                check("mon_result", 80'(result), 80'(e.res));
                check("mon_cout",   80'(cout),   80'(e.c));
                check("mon_zero",   80'(zero),   80'(e.z));
            end
        end
    end

    // Issues one op from idle and observes it until idle again.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit poke, output logic [NB-1:0] cseq,
                         output int busy_cyc, output int done_at, output bit oper_ok);
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_wait_timeout", 80'(busy), 80'(0));
        @(negedge clk);
        op_code = op; opa = a; opb = b; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(op, a, b, c));
        cseq     = '0;
        busy_cyc = 0;
        done_at  = -1;
        oper_ok  = 1'b1;
        for (int k = 0; k < NB + 3; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (busy) busy_cyc++;
            if (k < NB) begin
                cseq[k] = alu_c_in;
                if (alu_oper !== name_of(op)) oper_ok = 1'b0;
            end
            if (done && done_at < 0) done_at = k;
            if (poke && (k == 1 || k == NB)) begin
                op_code = ~op; opa = ~a; opb = ~b; cin = ~c; start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    logic [NB-1:0] cseq;
    int            bcyc, dat;
    bit            ook;
    exp_t          e0;

    initial begin
        rst = 1'b1; start = 1'b0; op_code = '0; opa = '0; opb = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   80'(busy),   80'(0));
        check("rst_result", 80'(result), 80'(0));
        check("rst_oper",   alu_oper,    name_of(3'd0));
        check("rst_alu_a",  80'(alu_a),  80'(0));
        @(negedge clk);
        rst = 1'b0;

        // Add carry ripple
        do_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, cseq, bcyc, dat, ook);
        check("add_res",     80'(result), 80'(32'h0000_0100));
        check("add_cout",    80'(cout),   80'(0));
        check("add_zero",    80'(zero),   80'(0));
        check("add_done_at", 80'(dat),    80'(NB));
        check("add_busy",    80'(bcyc),   80'(NB + 1));
        check("add_cseq",    80'(cseq),   80'(4'b0010));

        // Add wrap
        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, cseq, bcyc, dat, ook);
        check("wrap_res",  80'(result), 80'(0));
        check("wrap_cout", 80'(cout),   80'(1));
        check("wrap_zero", 80'(zero),   80'(1));

        // Subtract
        do_op(3'd1, 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0, cseq, bcyc, dat, ook);
        check("sub_res",  80'(result), 80'(32'h0000_00FF));
        check("sub_cout", 80'(cout),   80'(1));
        check("sub_cseq", 80'(cseq),   80'(4'b1101));

        // Reverse subtract
        do_op(3'd2, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, cseq, bcyc, dat, ook);
        check("rsub_res",  80'(result), 80'(32'h0000_00FF));
        check("rsub_cout", 80'(cout),   80'(1));
        check("rsub_cseq", 80'(cseq),   80'(4'b0010));

        // Logic exor
        do_op(3'd6, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b1, 1'b0, cseq, bcyc, dat, ook);
        check("xor_res",  80'(result), 80'(32'h5A5A_A5A5));
        check("xor_cout", 80'(cout),   80'(0));
        check("xor_cseq", 80'(cseq),   80'(0));
        check("xor_oper", 80'(ook),    80'(1));

        // Start while busy is ignored; result held afterwards
        do_op(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, cseq, bcyc, dat, ook);
        repeat (3) @(negedge clk);
        check("poke_busy",   80'(busy),   80'(0));
        check("poke_result", 80'(result), 80'(32'h2345_6789));

        // Reset after byte 1 captured
        @(negedge clk);
        op_code = 3'd0; opa = 32'h0102_0304; opb = 32'h1020_3040; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy",   80'(busy),     80'(0));
        check("abort_done",   80'(done),     80'(0));
        check("abort_result", 80'(result),   80'(0));
        check("abort_cout",   80'(cout),     80'(0));
        check("abort_zero",   80'(zero),     80'(0));
        check("abort_cin",    80'(alu_c_in), 80'(0));
        check("abort_alu_b",  80'(alu_b),    80'(0));
        check("abort_oper",   alu_oper,      name_of(3'd0));
        @(negedge clk);
        rst = 1'b0;
        repeat (NB + 2) @(negedge clk);
        check("abort_nodone", 80'(busy), 80'(0));

        // Fresh op after reset
        do_op(3'd1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, cseq, bcyc, dat, ook);
        check("post_rst_res",  80'(result), 80'(32'hFFFF_FFFF));
        check("post_rst_cout", 80'(cout),   80'(0));

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra, rb;
            logic         rc;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) rb = -ra;
            rc  = 1'($urandom_range(0, 1));
            do_op(rop, ra, rb, rc, ($urandom_range(0, 3) == 0), cseq, bcyc, dat, ook);
            check("rnd_done_at", 80'(dat), 80'(NB));
            check("rnd_oper",    80'(ook), 80'(1));
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 80'(sb.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
